// File: rtl/game_ctrl_if.sv
// Bundle between the game controller and the timer/display side: event inputs, timer control, score and lives.
// Optional GAME_CTRL_HIGH_SCORE_EN adds best_score and new_best.
interface game_ctrl_if;
  logic        hit;
  logic        miss;
  logic        game_over;
  logic        timer_reset;
  logic        playing;
  logic        game_end;
  logic [15:0] score;
  logic [3:0]  lives;
`ifdef GAME_CTRL_HIGH_SCORE_EN
  logic [15:0] best_score;
  logic        new_best;
`endif

`ifdef GAME_CTRL_HIGH_SCORE_EN
  modport master (input hit, miss, game_over,
                  output timer_reset, playing, game_end, score, lives, best_score, new_best);
  modport slave  (output hit, miss, game_over,
                  input timer_reset, playing, game_end, score, lives, best_score, new_best);
`else
  modport master (input hit, miss, game_over,
                  output timer_reset, playing, game_end, score, lives);
  modport slave  (output hit, miss, game_over,
                  input timer_reset, playing, game_end, score, lives);
`endif
endinterface

// File: rtl/game_ctrl.sv
// Game sequencer: debounced start button, IDLE/ARM/PLAY/OVER FSM, BCD score and lives; all outputs registered.
// Start press reaches start_p DEBOUNCE_CYCLES+2 cycles after a clean edge; GAME_CTRL_HIGH_SCORE_EN adds best-score tracking.
module game_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ARM_CYCLES      = 16,
  parameter int LIVES           = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        btn_start,
  game_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, ARM, PLAY, OVER} state_t;

  localparam logic [19:0] DEB_LAST   = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  ARM_LAST   = 8'(ARM_CYCLES - 1);
  localparam logic [3:0]  LIVES_INIT = 4'(LIVES);

  logic        sync1, sync2, deb_lvl, start_p;
  logic [19:0] deb_cnt;
  state_t      state_q, state_nxt;
  logic [7:0]  arm_cnt;
  logic        timer_reset_q, playing_q, game_end_q;
  logic [15:0] score_q, score_play;
  logic [3:0]  lives_q;
  logic        restart, fatal;

  // Per-digit BCD increment with carry; 9999 saturates.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb_lvl <= 1'b0;
      deb_cnt <= 20'd0;
      start_p <= 1'b0;
    end else begin
      sync1   <= btn_start;
      sync2   <= sync1;
      start_p <= 1'b0;
      if (sync2 == deb_lvl) begin
        deb_cnt <= 20'd0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_lvl <= sync2;
        deb_cnt <= 20'd0;
        start_p <= sync2;   // only an accepted rising level starts a game
      end else begin
        deb_cnt <= deb_cnt + 20'd1;
      end
    end
  end

  assign restart    = start_p && (state_q == IDLE || state_q == OVER);
  assign score_play = bus.hit ? bcd_inc(score_q) : score_q;
  assign fatal      = bus.miss && (lives_q == 4'd1);

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (start_p) state_nxt = ARM;
      ARM:     if (arm_cnt == ARM_LAST) state_nxt = PLAY;
      PLAY:    if (bus.game_over || fatal) state_nxt = OVER;
      OVER:    if (start_p) state_nxt = ARM;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      arm_cnt       <= 8'd0;
      timer_reset_q <= 1'b1;
      playing_q     <= 1'b0;
      game_end_q    <= 1'b0;
      score_q       <= 16'h0000;
      lives_q       <= LIVES_INIT;
    end else begin
      state_q       <= state_nxt;
      timer_reset_q <= (state_nxt == IDLE) || (state_nxt == ARM);
      playing_q     <= (state_nxt == PLAY);
      game_end_q    <= (state_nxt == OVER);
      arm_cnt       <= (state_q == ARM) ? arm_cnt + 8'd1 : 8'd0;
      if (restart) begin
        score_q <= 16'h0000;
        lives_q <= LIVES_INIT;
      end else if (state_q == PLAY) begin
        score_q <= score_play;
        if (bus.miss && lives_q != 4'd0) lives_q <= lives_q - 4'd1;
      end
    end
  end

  assign bus.timer_reset = timer_reset_q;
  assign bus.playing     = playing_q;
  assign bus.game_end    = game_end_q;
  assign bus.score       = score_q;
  assign bus.lives       = lives_q;

`ifdef GAME_CTRL_HIGH_SCORE_EN
  logic [15:0] best_q;
  logic        new_best_q;

  // BCD values order the same as binary, so a plain compare picks the higher score.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      best_q     <= 16'h0000;
      new_best_q <= 1'b0;
    end else if (state_q == PLAY && state_nxt == OVER && score_play > best_q) begin
      best_q     <= score_play;
      new_best_q <= 1'b1;
    end else if (state_q != ARM && state_nxt == ARM) begin
      new_best_q <= 1'b0;
    end
  end

  assign bus.best_score = best_q;
  assign bus.new_best   = new_best_q;
`endif
endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with DEBOUNCE_CYCLES=4, ARM_CYCLES=3, LIVES=3.
// Table vectors for in-game events plus hand sequences for start, saturation, game_over and async reset.
module tb_game_ctrl;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic btn_start = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;

  game_ctrl_if bus();

  game_ctrl #(.DEBOUNCE_CYCLES(4), .ARM_CYCLES(3), .LIVES(3)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .btn_start (btn_start),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (dut.start_p) start_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        h, m, g;
    logic [15:0] score;
    logic [3:0]  lives;
    logic        play, fin;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic h, input logic m, input logic g);
    @(negedge clock);
    bus.hit = h; bus.miss = m; bus.game_over = g;
    @(posedge clock);
    #1;
    bus.hit = 1'b0; bus.miss = 1'b0; bus.game_over = 1'b0;
  endtask

  task automatic hits(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0);
  endtask

  // Release, bounce, then hold the button; follow the game through ARM into PLAY.
  task automatic press();
    int base, n, m, tr_bad;
    btn_start = 1'b0;
    repeat (10) @(negedge clock);
    base = start_cnt;
    chk("no_start_on_release", start_cnt - base, 0);
    repeat (2) begin
      btn_start = 1'b1; repeat (2) @(negedge clock);
      btn_start = 1'b0; repeat (2) @(negedge clock);
    end
    chk("no_start_on_bounce", start_cnt - base, 0);
    btn_start = 1'b1;
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!dut.start_p && n < 30);
    chk("start_latency", n, 6);
    m = 0; tr_bad = 0;
    do begin
      @(posedge clock); #1; m++;
      if (m == 1) begin
        chk("arm_score_clear", bus.score, 16'h0000);
        chk("arm_lives_load", bus.lives, 3);
`ifdef GAME_CTRL_HIGH_SCORE_EN
        chk("arm_new_best_clear", bus.new_best, 0);
`endif
        bus.hit = 1'b1; bus.miss = 1'b1;   // must be ignored in ARM
      end
      if (m == 3) begin bus.hit = 1'b0; bus.miss = 1'b0; end
      if (!bus.playing && bus.timer_reset !== 1'b1) tr_bad++;
    end while (!bus.playing && m < 30);
    bus.hit = 1'b0; bus.miss = 1'b0;
    chk("arm_length", m, 4);
    chk("arm_timer_reset_high", tr_bad, 0);
    chk("single_start_pulse", start_cnt - base, 1);
    chk("play_timer_reset", bus.timer_reset, 0);
    chk("play_score", bus.score, 16'h0000);
    chk("play_lives", bus.lives, 3);
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b0, 1'b0, 16'h0001, 4'd3, 1'b1, 1'b0};
    vt[1] = '{1'b1, 1'b1, 1'b0, 16'h0002, 4'd2, 1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b0, 16'h0002, 4'd2, 1'b1, 1'b0};
    vt[3] = '{1'b0, 1'b1, 1'b0, 16'h0002, 4'd1, 1'b1, 1'b0};
    vt[4] = '{1'b1, 1'b0, 1'b0, 16'h0003, 4'd1, 1'b1, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b0, 16'h0004, 4'd0, 1'b0, 1'b1};
    vt[6] = '{1'b1, 1'b0, 1'b0, 16'h0004, 4'd0, 1'b0, 1'b1};
    vt[7] = '{1'b0, 1'b1, 1'b0, 16'h0004, 4'd0, 1'b0, 1'b1};
    vt[8] = '{1'b0, 1'b0, 1'b1, 16'h0004, 4'd0, 1'b0, 1'b1};

    bus.hit = 1'b0; bus.miss = 1'b0; bus.game_over = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("rst_timer_reset", bus.timer_reset, 1);
    chk("rst_playing", bus.playing, 0);
    chk("rst_game_end", bus.game_end, 0);
    chk("rst_score", bus.score, 16'h0000);
    chk("rst_lives", bus.lives, 3);
`ifdef GAME_CTRL_HIGH_SCORE_EN
    chk("rst_best", bus.best_score, 16'h0000);
    chk("rst_new_best", bus.new_best, 0);
`endif

    // Game 1: mixed events from the table, ending on a fatal miss with a hit.
    press();
    for (int i = 0; i < 9; i++) begin
      step(vt[i].h, vt[i].m, vt[i].g);
      chk($sformatf("vec%0d_score", i), bus.score, vt[i].score);
      chk($sformatf("vec%0d_lives", i), bus.lives, vt[i].lives);
      chk($sformatf("vec%0d_playing", i), bus.playing, vt[i].play);
      chk($sformatf("vec%0d_game_end", i), bus.game_end, vt[i].fin);
      chk($sformatf("vec%0d_timer_reset", i), bus.timer_reset, 0);
    end
`ifdef GAME_CTRL_HIGH_SCORE_EN
    chk("g1_best", bus.best_score, 16'h0004);
    chk("g1_new_best", bus.new_best, 1);
`endif

    // Game 2: BCD carries and saturation, then three misses.
    press();
    hits(12);
    chk("score_0012", bus.score, 16'h0012);
    hits(987);
    chk("score_0999", bus.score, 16'h0999);
    hits(1);
    chk("score_1000", bus.score, 16'h1000);
    hits(8999);
    chk("score_9999", bus.score, 16'h9999);
    hits(1);
    chk("score_saturate", bus.score, 16'h9999);
    step(1'b0, 1'b1, 1'b0);
    chk("miss1_lives", bus.lives, 2);
    step(1'b0, 1'b1, 1'b0);
    chk("miss2_lives", bus.lives, 1);
    chk("miss2_playing", bus.playing, 1);
    step(1'b0, 1'b1, 1'b0);
    chk("miss3_lives", bus.lives, 0);
    chk("miss3_game_end", bus.game_end, 1);
    chk("miss3_playing", bus.playing, 0);
`ifdef GAME_CTRL_HIGH_SCORE_EN
    chk("g2_best", bus.best_score, 16'h9999);
    chk("g2_new_best", bus.new_best, 1);
`endif

    // Game 3: hit coincident with game_over is counted.
    press();
    hits(5);
    step(1'b1, 1'b0, 1'b1);
    chk("go_hit_score", bus.score, 16'h0006);
    chk("go_game_end", bus.game_end, 1);
    chk("go_lives", bus.lives, 3);
    chk("go_timer_reset", bus.timer_reset, 0);
`ifdef GAME_CTRL_HIGH_SCORE_EN
    chk("g3_best_kept", bus.best_score, 16'h9999);
    chk("g3_new_best", bus.new_best, 0);
`endif

    // Game 4: asynchronous reset mid-play.
    press();
    hits(42);
    step(1'b0, 1'b1, 1'b0);
    chk("pre_rst_score", bus.score, 16'h0042);
    chk("pre_rst_lives", bus.lives, 2);
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_score", bus.score, 16'h0000);
    chk("async_rst_lives", bus.lives, 3);
    chk("async_rst_timer_reset", bus.timer_reset, 1);
    chk("async_rst_playing", bus.playing, 0);
    chk("async_rst_game_end", bus.game_end, 0);
    @(negedge clock);
    reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
